// File: rtl/mul8_share_pkg.sv
// Shared widths and the round-robin pick helper for the mul8 sharing arbiter.
package mul8_share_pkg;
   localparam int MUL8_W  = 8;
   localparam int MUL8_PW = 16;

   typedef struct packed {
      logic       found;
      logic [2:0] idx;
   } pick_t;

   // First set bit of valid scanning ptr, ptr+1, ... modulo nreq (nreq <= 8).
   function automatic pick_t rr_pick(input logic [7:0] valid, input logic [2:0] ptr, input int nreq);
      pick_t p;
      int    j;
      p = '0;
      for (int k = 0; k < 8; k++) begin
         j = (int'(ptr) + k) % nreq;
         if (k < nreq && !p.found && valid[j[2:0]]) begin
            p.found = 1'b1;
            p.idx   = j[2:0];
         end
      end
      return p;
   endfunction
endpackage

// File: rtl/mul8_share_arb_if.sv
// Request/response bundle between NREQ requesters, the shared multiplier and its consumer.
interface mul8_share_arb_if
   import mul8_share_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = 2
);
   logic [NREQ-1:0]        req_valid;
   logic [NREQ-1:0]        req_ready;
   logic [NREQ*MUL8_W-1:0] req_a;
   logic [NREQ*MUL8_W-1:0] req_b;
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [IDW-1:0]         rsp_id;
   logic [MUL8_PW-1:0]     rsp_o;

   modport master (output req_valid, req_a, req_b, rsp_ready,
                   input  req_ready, rsp_valid, rsp_id, rsp_o);
   modport slave  (input  req_valid, req_a, req_b, rsp_ready,
                   output req_ready, rsp_valid, rsp_id, rsp_o);
endinterface

// File: rtl/mul8_share_arb_rr.sv
// Round-robin picker: one-hot grant to the first valid requester at/after rr_ptr.
// Combinational grant; pointer moves to the slot after the winner only when a grant is issued.
module mul8_rr_arb
   import mul8_share_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic [NREQ-1:0] valid,
   output logic [NREQ-1:0] grant,
   output logic            gnt,
   output logic [IDW-1:0]  gnt_idx
);
   logic [IDW-1:0] rr_ptr;
   pick_t          pick;

   always_comb begin
      pick    = rr_pick(8'(valid), 3'(rr_ptr), NREQ);
      gnt     = en & pick.found;
      gnt_idx = IDW'(pick.idx);
      grant   = gnt ? (NREQ'(1) << pick.idx) : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr <= '0;
      end else if (gnt) begin
         rr_ptr <= (int'(pick.idx) == NREQ - 1) ? '0 : gnt_idx + IDW'(1);
      end
   end
endmodule

// File: rtl/mul8_share_arb.sv
// Shares one external combinational 8x8 multiplier among NREQ requesters; 2-stage pipe, 1 op/cycle.
// rsp_ready low freezes stage 2; stage 1 then refills only if empty, otherwise req_ready drops to 0.
module mul8_share_arb
   import mul8_share_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = 2,
   parameter int CNTW = 32
) (
   input  logic               clk,
   input  logic               rst,
   mul8_share_arb_if.slave    bus,
   output logic [MUL8_W-1:0]  mul_a,
   output logic [MUL8_W-1:0]  mul_b,
   input  logic [MUL8_PW-1:0] mul_o,
   output logic               busy,
   output logic [CNTW-1:0]    op_count
);
   logic               s1_v, s2_v, s1_adv, s2_adv, gnt;
   logic [NREQ-1:0]    grant;
   logic [IDW-1:0]     gnt_idx, s1_id, rsp_id_q;
   logic [MUL8_W-1:0]  s1_a, s1_b, a_sel, b_sel;
   logic [MUL8_PW-1:0] rsp_o_q;

   assign s2_adv = !s2_v | bus.rsp_ready;
   assign s1_adv = !s1_v | s2_adv;

   // Gating with rst keeps a requester from seeing a handshake that reset would discard.
   mul8_rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
      .clk     (clk),
      .rst     (rst),
      .en      (s1_adv & !rst),
      .valid   (bus.req_valid),
      .grant   (grant),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   always_comb begin
      a_sel = '0;
      b_sel = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            a_sel = bus.req_a[i*MUL8_W +: MUL8_W];
            b_sel = bus.req_b[i*MUL8_W +: MUL8_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_v     <= 1'b0;
         s2_v     <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_id    <= '0;
         rsp_id_q <= '0;
         rsp_o_q  <= '0;
         op_count <= '0;
      end else begin
         if (s1_adv) begin
            s1_v <= gnt;
            if (gnt) begin
               s1_a  <= a_sel;
               s1_b  <= b_sel;
               s1_id <= gnt_idx;
            end
         end
         if (s2_adv) begin
            s2_v <= s1_v;
            if (s1_v) begin
               rsp_o_q  <= mul_o;
               rsp_id_q <= s1_id;
            end
         end
         if (gnt) op_count <= op_count + CNTW'(1);
      end
   end

   assign bus.req_ready = grant;
   assign bus.rsp_valid = s2_v & !rst;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_o     = rsp_o_q;
   assign mul_a         = s1_a;
   assign mul_b         = s1_b;
   assign busy          = s1_v | s2_v;
endmodule
